hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Issue controller between decode and execute. Tracks in-flight multi-cycle results (loads, MUL) per
//  architectural register and decides each cycle whether the decoded instruction may issue.
//  Stalls decode on RAW/WAW hazards, on the non-pipelined multiplier being busy, and on
//  write-back port collisions between loads and MULs.
//  Single-cycle ALU results bypass the scoreboard via forwarding and are never tracked.
// PARAMETERS
//  NREG     32  number of architectural registers (index width = $clog2(NREG), 5 at default)
//  LD_LAT   2   cycles from load issue to its write-back; must satisfy 1 <= LD_LAT < MUL_LAT
//  MUL_LAT  4   cycles from MUL issue to its write-back; multiplier accepts one op at a time
//  CNT_W    3   per-register countdown width; must hold MUL_LAT
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     reset, asynchronous, active-high
//  D_valid      in   1     decode holds a real instruction this cycle
//  D_ra         in   5     source register A
//  D_rb         in   5     source register B
//  D_rd         in   5     destination register
//  D_ra_used    in   1     instruction reads ra
//  D_rb_used    in   1     instruction reads rb
//  D_we         in   1     instruction writes rd
//  D_ld         in   1     instruction is a load
//  D_mul        in   1     instruction is a MUL
//  stall        out  1     hold fetch/decode; present instruction not issued
//  issue        out  1     D_valid && !stall; instruction enters execute this cycle
//  busy_vec     out  NREG  bit r set when cnt[r] != 0
//  stall_cnt    out  32    saturating count of cycles with stall=1
// BEHAVIOUR
//  Reset (async): all cnt[r]=0, mul_cnt=0, wb_res=0, stall_cnt=0
//   -> busy_vec=0; stall=0, issue=D_valid until first clock.
//   Reset mid-operation discards all in-flight tracking immediately.
//  State
//   - cnt[r] CNT_W per register.
//   - mul_cnt CNT_W.
//   - wb_res[MUL_LAT-1:0]: bit k set means a write-back is reserved k+1 edges after the next edge.
//  stall (combinational from state + decode inputs, zero latency), OR of:
//   raw  : (D_ra_used && D_ra!=0 && cnt[D_ra]!=0) || (D_rb_used && D_rb!=0 && cnt[D_rb]!=0)
//   waw  : D_we && D_rd!=0 && cnt[D_rd]!=0
//   smul : D_mul && mul_cnt!=0
//   wbc  : D_ld && wb_res[LD_LAT]
//   All four terms gated by D_valid; stall=0 whenever D_valid=0.
//  Per edge
//   - Every nonzero cnt[r] and mul_cnt decrements by 1.
//   - On issue && D_we && D_rd!=0 && (D_ld|D_mul): cnt[D_rd] <= D_mul ? MUL_LAT : LD_LAT.
//     Load overrides the decrement; WAW stall guarantees the old value was 0.
//   - On issue && D_mul: mul_cnt <= MUL_LAT.
//   - wb_res <= (wb_res >> 1) | (issue&&D_ld ? 1<<(LD_LAT-1) : 0) | (issue&&D_mul ? 1<<(MUL_LAT-1) : 0).
//   - stall_cnt increments when stall=1; holds at 32'hFFFF_FFFF.
//  Register r0 is never marked busy and never causes a stall.
//  Loads and MULs with D_we=0 still reserve wb_res / mul_cnt. D_ld && D_mul together: MUL wins.
//  Non-tracked instructions issue whenever no raw/waw term fires.
// STRUCTURE
//  - Shared package hazard_pkg: LD_LAT/MUL_LAT defaults, register-index width, stall-cause enum
//    {RAW, WAW, SMUL, WBC}.
//  - One sub-module sb_cnt: CNT_W loadable down-counter with busy flag, generated NREG-1 times (r1..r31).
//    mul_cnt reuses sb_cnt.
// TESTING (LD_LAT=2, MUL_LAT=4; cycle 0 = issue cycle)
//  1. ld r5 @0, then add r6,r5,r1 presented @1 -> stall=1 @1,@2; issue=1 @3; busy_vec[5] high @1..@2.
//  2. mul r3 @0, mul r4 presented @1 -> stall=1 @1..@4 (smul); issue @5; stall_cnt=4.
//  3. mul r3 @0, ld r7 presented @2 -> stall=1 @2 (wbc, both would write back @4); issue @3.
//     ld presented @1 issues @1 with no stall.
//  4. ld r0 @0, add reading r0 @1 -> stall=0, busy_vec=0 throughout.
//  5. ld r5 @0, mul r5 presented @1 -> waw stall @1,@2; issue @3; cnt[5]=4 @4.
//  6. mul r9 @0, rst pulsed mid-cycle @2 -> busy_vec=0 and stall=0 immediately, without waiting for a clock edge.
//     Dependent read of r9 @3 issues with no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared scoreboard constants and the stall-cause encoding.
package hazard_pkg;

  localparam int unsigned HZ_NREG    = 32;
  localparam int unsigned HZ_LD_LAT  = 2;
  localparam int unsigned HZ_MUL_LAT = 4;
  localparam int unsigned HZ_CNT_W   = 3;
  localparam int unsigned HZ_REG_W   = $clog2(HZ_NREG);

  // Bit positions of the individual stall causes inside the cause vector.
  typedef enum logic [1:0] {
    CAUSE_RAW  = 2'd0,
    CAUSE_WAW  = 2'd1,
    CAUSE_SMUL = 2'd2,
    CAUSE_WBC  = 2'd3
  } stall_cause_e;

  localparam int unsigned HZ_NCAUSE = 4;

endpackage

// File: rtl/hazard_scoreboard_sb_cnt.sv
// Loadable saturating-at-zero down-counter with a busy flag.
module sb_cnt
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = HZ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A load overrides the countdown; otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_c = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-to-execute issue controller: tracks pending load/MUL results and
// stalls decode on RAW/WAW hazards, a busy multiplier, or write-back collisions.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG    = HZ_NREG,
  parameter int unsigned LD_LAT  = HZ_LD_LAT,
  parameter int unsigned MUL_LAT = HZ_MUL_LAT,
  parameter int unsigned CNT_W   = HZ_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                D_valid,
  input  logic [HZ_REG_W-1:0] D_ra,
  input  logic [HZ_REG_W-1:0] D_rb,
  input  logic [HZ_REG_W-1:0] D_rd,
  input  logic                D_ra_used,
  input  logic                D_rb_used,
  input  logic                D_we,
  input  logic                D_ld,
  input  logic                D_mul,
  output logic                stall,
  output logic                issue,
  output logic [NREG-1:0]     busy_vec,
  output logic [31:0]         stall_cnt
);

  logic [HZ_NCAUSE-1:0] cause_c;
  logic                 mul_busy_c;
  logic [CNT_W-1:0]     trk_val_c;
  logic                 trk_c;
  logic [MUL_LAT-1:0]   wb_res_q;
  logic [MUL_LAT-1:0]   wb_res_d;
  logic [31:0]          stall_cnt_q;
  logic [31:0]          stall_cnt_d;

  // A tracked result (load or MUL) that actually writes a register.
  assign trk_c     = issue && D_we && (D_ld || D_mul);
  assign trk_val_c = D_mul ? CNT_W'(MUL_LAT) : CNT_W'(LD_LAT);

  // r0 is hardwired: never tracked, never busy.
  assign busy_vec[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_reg
      logic load_c;
      assign load_c = trk_c && (D_rd == HZ_REG_W'(r));
      sb_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .load_val (trk_val_c),
        .busy_c   (busy_vec[r])
      );
    end
  endgenerate

  // Multiplier occupancy: not pipelined, one op in flight at a time.
  sb_cnt #(.CNT_W(CNT_W)) u_mul_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (issue && D_mul),
    .load_val (CNT_W'(MUL_LAT)),
    .busy_c   (mul_busy_c)
  );

  // Zero-latency hazard detection on the instruction sitting in decode.
  always_comb begin
    cause_c = '0;
    if (D_valid) begin
      cause_c[CAUSE_RAW]  = (D_ra_used && (D_ra != '0) && busy_vec[D_ra]) ||
                            (D_rb_used && (D_rb != '0) && busy_vec[D_rb]);
      cause_c[CAUSE_WAW]  = D_we && (D_rd != '0) && busy_vec[D_rd];
      cause_c[CAUSE_SMUL] = D_mul && mul_busy_c;
      cause_c[CAUSE_WBC]  = D_ld && wb_res_q[LD_LAT];
    end
    stall = |cause_c;
    issue = D_valid && !stall;
  end

  // Write-back port reservations slide one slot closer each edge.
  always_comb begin
    wb_res_d = wb_res_q >> 1;
    if (issue && D_ld) begin
      wb_res_d[LD_LAT-1] = 1'b1;
    end
    if (issue && D_mul) begin
      wb_res_d[MUL_LAT-1] = 1'b1;
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Reservation and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_res_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_res_q    <= wb_res_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard (LD_LAT=2, MUL_LAT=4).
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        D_valid;
  logic [4:0]  D_ra;
  logic [4:0]  D_rb;
  logic [4:0]  D_rd;
  logic        D_ra_used;
  logic        D_rb_used;
  logic        D_we;
  logic        D_ld;
  logic        D_mul;
  logic        stall;
  logic        issue;
  logic [31:0] busy_vec;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_scoreboard dut (
    .clk       (clk),
    .rst       (rst),
    .D_valid   (D_valid),
    .D_ra      (D_ra),
    .D_rb      (D_rb),
    .D_rd      (D_rd),
    .D_ra_used (D_ra_used),
    .D_rb_used (D_rb_used),
    .D_we      (D_we),
    .D_ld      (D_ld),
    .D_mul     (D_mul),
    .stall     (stall),
    .issue     (issue),
    .busy_vec  (busy_vec),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Present one decoded instruction.
  task automatic ins(input logic v, input int ra, input int rb, input int rd,
                     input logic rau, input logic rbu, input logic we,
                     input logic ld, input logic mul);
    D_valid   = v;
    D_ra      = 5'(ra);
    D_rb      = 5'(rb);
    D_rd      = 5'(rd);
    D_ra_used = rau;
    D_rb_used = rbu;
    D_we      = we;
    D_ld      = ld;
    D_mul     = mul;
  endtask

  task automatic idle();
    ins(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Reset pulse placed away from clock edges, then step to the start of cycle 0.
  task automatic do_reset();
    idle();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    next_cycle();
  endtask

  // Check stall/issue in the middle of the current cycle.
  task automatic si(input string tag, input logic exp_stall, input logic exp_issue);
    mid();
    check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    check({tag, "_issue"}, 32'(issue), 32'(exp_issue));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3;
    // Reset state; a plain ALU op must see issue=D_valid during reset.
    ins(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("rst_busy", busy_vec, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_issue", 32'(issue), 32'd1);
    check("rst_scnt", stall_cnt, 32'd0);

    // 1. ld r5, then add r6,r5,r1 -> RAW stall for two cycles.
    do_reset();
    ins(1'b1, 0, 0, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    si("t1_c0", 1'b0, 1'b1);
    next_cycle();
    ins(1'b1, 5, 1, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    si("t1_c1", 1'b1, 1'b0);
    check("t1_c1_busy5", 32'(busy_vec[5]), 32'd1);
    next_cycle();
    si("t1_c2", 1'b1, 1'b0);
    check("t1_c2_busy5", 32'(busy_vec[5]), 32'd1);
    next_cycle();
    si("t1_c3", 1'b0, 1'b1);
    check("t1_c3_busy", busy_vec, 32'h0);
    check("t1_c3_scnt", stall_cnt, 32'd2);

    // 2. mul r3, then mul r4 -> structural stall for four cycles.
    do_reset();
    ins(1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    si("t2_c0", 1'b0, 1'b1);
    next_cycle();
    ins(1'b1, 0, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      si($sformatf("t2_c%0d", c), 1'b1, 1'b0);
      next_cycle();
    end
    si("t2_c5", 1'b0, 1'b1);
    check("t2_c5_scnt", stall_cnt, 32'd4);
    check("t2_c5_busy", busy_vec, 32'h0000_0008 & 32'h0);

    // 3a. mul r3, ld r7 presented @2 -> write-back collision stall.
    do_reset();
    ins(1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    si("t3a_c0", 1'b0, 1'b1);
    next_cycle();
    idle();
    si("t3a_c1", 1'b0, 1'b0);
    next_cycle();
    ins(1'b1, 0, 0, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    si("t3a_c2", 1'b1, 1'b0);
    next_cycle();
    si("t3a_c3", 1'b0, 1'b1);

    // 3b. ld presented @1 lands before the MUL write-back: no stall.
    do_reset();
    ins(1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    next_cycle();
    ins(1'b1, 0, 0, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    si("t3b_c1", 1'b0, 1'b1);

    // 4. r0 is never tracked.
    do_reset();
    ins(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    si("t4_c0", 1'b0, 1'b1);
    next_cycle();
    ins(1'b1, 0, 0, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    si("t4_c1", 1'b0, 1'b1);
    check("t4_c1_busy", busy_vec, 32'h0);
    next_cycle();
    idle();
    mid();
    check("t4_c2_busy", busy_vec, 32'h0);

    // 5. ld r5, then mul r5 -> WAW stall, then r5 busy for MUL_LAT cycles.
    do_reset();
    ins(1'b1, 0, 0, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    next_cycle();
    ins(1'b1, 0, 0, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    si("t5_c1", 1'b1, 1'b0);
    next_cycle();
    si("t5_c2", 1'b1, 1'b0);
    next_cycle();
    si("t5_c3", 1'b0, 1'b1);
    next_cycle();
    idle();
    mid();
    check("t5_c4_busy", busy_vec, 32'h0000_0020);
    next_cycle();
    next_cycle();
    next_cycle();
    mid();
    check("t5_c7_busy5", 32'(busy_vec[5]), 32'd1);
    next_cycle();
    mid();
    check("t5_c8_busy5", 32'(busy_vec[5]), 32'd0);

    // 6. mul r9 then async reset mid-cycle clears tracking at once.
    do_reset();
    ins(1'b1, 0, 0, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    next_cycle();
    ins(1'b0, 9, 0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    si("t6_c1_novalid", 1'b0, 1'b0);
    check("t6_c1_busy", busy_vec, 32'h0000_0200);
    next_cycle();
    ins(1'b1, 9, 0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    si("t6_c2_pre", 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy_vec, 32'h0);
    check("t6_rst_stall", 32'(stall), 32'd0);
    check("t6_rst_issue", 32'(issue), 32'd1);
    #1;
    rst = 1'b0;
    next_cycle();
    si("t6_c3", 1'b0, 1'b1);
    check("t6_c3_scnt", stall_cnt, 32'd0);

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
